// File: rtl/sram_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_rr_arbiter_if : request/response ports and SRAM macro bus of the arbiter
// Revision: 1.0
// ============================================================================
interface sram_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  p0_valid;
    logic                  p0_ready;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_valid;
    logic                  p1_ready;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  sram_csb0;
    logic                  sram_web0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  sram_csb0, sram_web0, sram_addr0, sram_din0,
        output sram_dout0
    );

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output sram_csb0, sram_web0, sram_addr0, sram_din0,
        input  sram_dout0
    );
endinterface
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// sram_rr_arbiter : two-port round-robin arbiter/sequencer for a 1rw SRAM macro
// Optional macro SRAM_ARB_INIT_EN: zero-fill sweep of the whole array after reset.
// Revision: 1.0
// ============================================================================
module sram_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  wire logic         clk0,
    input  wire logic         rst0,
    sram_rr_arbiter_if.slave  bus,
    output logic              init_done
);
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef SRAM_ARB_INIT_EN
    localparam state_t C_RESET_STATE = ST_INIT;
`else
    localparam state_t C_RESET_STATE = ST_RUN;
`endif
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                r_state;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_last_p1;
    logic                  r_tag1_v;
    logic                  r_tag1_p;
    logic                  r_tag2_v;
    logic                  r_tag2_p;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;

    logic                  w_en;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // r_last_p1 resets high so port 0 wins the first contended cycle.
    assign w_en     = r_init_done && (r_state == ST_RUN) && !rst0;
    assign w_gnt0   = w_en && bus.p0_valid && (!bus.p1_valid || r_last_p1);
    assign w_gnt1   = w_en && bus.p1_valid && !w_gnt0;
    assign w_accept = w_gnt0 || w_gnt1;
    assign w_we     = w_gnt1 ? bus.p1_we    : bus.p0_we;
    assign w_addr   = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign w_wdata  = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state     <= C_RESET_STATE;
            r_init_done <= 1'b0;
            r_init_cnt  <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_addr      <= '0;
            r_din       <= '0;
            r_last_p1   <= 1'b1;
            r_tag1_v    <= 1'b0;
            r_tag1_p    <= 1'b0;
            r_tag2_v    <= 1'b0;
            r_tag2_p    <= 1'b0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            // Second tag stage lines up with dout0 being valid at this edge.
            r_tag2_v    <= r_tag1_v;
            r_tag2_p    <= r_tag1_p;
            r_p0_rvalid <= r_tag2_v && !r_tag2_p;
            r_p1_rvalid <= r_tag2_v &&  r_tag2_p;
            if (r_tag2_v && !r_tag2_p) r_p0_rdata <= bus.sram_dout0;
            if (r_tag2_v &&  r_tag2_p) r_p1_rdata <= bus.sram_dout0;
            r_tag1_v    <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    r_csb      <= 1'b0;
                    r_web      <= 1'b0;
                    r_din      <= '0;
                    r_addr     <= r_init_cnt;
                    r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                    if (r_init_cnt == C_LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_init_done <= 1'b1;
                    if (w_accept) begin
                        r_csb     <= 1'b0;
                        r_web     <= ~w_we;
                        r_addr    <= w_addr;
                        if (w_we) r_din <= w_wdata;
                        r_last_p1 <= w_gnt1;
                        r_tag1_v  <= ~w_we;
                        r_tag1_p  <= w_gnt1;
                    end else begin
                        r_csb     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.p0_ready   = w_gnt0;
    assign bus.p1_ready   = w_gnt1;
    assign bus.p0_rvalid  = r_p0_rvalid;
    assign bus.p1_rvalid  = r_p1_rvalid;
    assign bus.p0_rdata   = r_p0_rdata;
    assign bus.p1_rdata   = r_p1_rdata;
    assign bus.sram_csb0  = r_csb;
    assign bus.sram_web0  = r_web;
    assign bus.sram_addr0 = r_addr;
    assign bus.sram_din0  = r_din;
    assign init_done      = r_init_done;
endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_rr_arbiter : directed self-checking bench with a behavioural 1rw SRAM
// Revision: 1.0
// ============================================================================
module tb_sram_rr_arbiter;
    localparam int DW = 32;
    localparam int AW = 7;

    logic clk0 = 1'b0;
    logic rst0 = 1'b1;
    logic init_done;
    int   checks = 0;
    int   errors = 0;

    sram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .bus       (bus.slave),
        .init_done (init_done)
    );

    always #5 clk0 = ~clk0;

    // Macro model: capture at posedge, access at the following negedge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          m_csb  = 1'b1;
    logic          m_web  = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din  = '0;
    logic [DW-1:0] m_dout = '0;
    assign bus.sram_dout0 = m_dout;

    always @(posedge clk0) begin
        m_csb  <= bus.sram_csb0;
        m_web  <= bus.sram_web0;
        m_addr <= bus.sram_addr0;
        m_din  <= bus.sram_din0;
    end

    always @(negedge clk0) begin
        if (!m_csb) begin
            if (!m_web) mem[m_addr] <= m_din;
            else        m_dout      <= mem[m_addr];
        end
    end

    task automatic set_idle();
        bus.p0_valid = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    endtask

    task automatic do_reset();
        int n;
        set_idle();
        rst0 = 1'b1;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        n = 0;
        while (!init_done && n < 300) begin
            @(negedge clk0);
            n++;
        end
        checks++;
        if (!init_done) begin
            errors++;
            $display("FAIL reset_init_timeout init_done=%0b required 1", init_done);
        end
    endtask

    // Single-requester write; lone valid guarantees acceptance at the next edge.
    task automatic do_write(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin bus.p1_valid = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = a; bus.p1_wdata = d; end
        else      begin bus.p0_valid = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = a; bus.p0_wdata = d; end
        @(posedge clk0);
        @(negedge clk0);
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        bus.p0_valid = 1'b1;
        bus.p1_valid = 1'b1;
        rst0 = 1'b1;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        checks++; if (bus.sram_csb0 !== 1'b1) begin errors++; $display("FAIL rst_csb0 got %b required 1", bus.sram_csb0); end
        checks++; if (bus.sram_web0 !== 1'b1) begin errors++; $display("FAIL rst_web0 got %b required 1", bus.sram_web0); end
        checks++; if (bus.sram_addr0 !== 7'h00) begin errors++; $display("FAIL rst_addr0 got %h required 00", bus.sram_addr0); end
        checks++; if (bus.sram_din0 !== 32'h0) begin errors++; $display("FAIL rst_din0 got %h required 0", bus.sram_din0); end
        checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b required 00", {bus.p0_rvalid, bus.p1_rvalid}); end
        checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h required 0/0", bus.p0_rdata, bus.p1_rdata); end
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b required 00", {bus.p0_ready, bus.p1_ready}); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b required 0", init_done); end
        set_idle();
        rst0 = 1'b0;
`ifndef SRAM_ARB_INIT_EN
        @(negedge clk0);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL run_init_done got %b required 1", init_done); end
`endif
    endtask

    task automatic test_write_read();
        do_reset();
        bus.p0_valid = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 7'h05; bus.p0_wdata = 32'hDEADBEEF;
        #1;
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin errors++; $display("FAIL wr_ready got %b required 10", {bus.p0_ready, bus.p1_ready}); end
        @(posedge clk0); @(negedge clk0);
        checks++; if ({bus.sram_csb0, bus.sram_web0} !== 2'b00 || bus.sram_addr0 !== 7'h05 || bus.sram_din0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_issue got csb/web=%b addr=%h din=%h required 00 05 deadbeef", {bus.sram_csb0, bus.sram_web0}, bus.sram_addr0, bus.sram_din0);
        end
        bus.p0_we = 1'b0;
        @(posedge clk0); @(negedge clk0);
        set_idle();
        checks++; if ({bus.sram_csb0, bus.sram_web0} !== 2'b01 || bus.sram_din0 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_issue got csb/web=%b din=%h required 01 deadbeef", {bus.sram_csb0, bus.sram_web0}, bus.sram_din0);
        end
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.p0_rvalid !== 1'b0 || bus.sram_csb0 !== 1'b1) begin errors++; $display("FAIL rd_early got rvalid=%b csb0=%b required 0 1", bus.p0_rvalid, bus.sram_csb0); end
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_return got rvalid=%b rdata=%h required 1 deadbeef", bus.p0_rvalid, bus.p0_rdata); end
        checks++; if (bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_other got p1_rvalid=%b required 0", bus.p1_rvalid); end
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse got rvalid=%b required 0", bus.p0_rvalid); end
    endtask

    task automatic test_alternate();
        bit            exp_p;
        logic [DW-1:0] exp_d;
        do_reset();
        do_write(1'b1, 7'h01, 32'h11111111);
        do_write(1'b1, 7'h02, 32'h22222222);
        for (int k = 0; k < 10; k++) begin
            bus.p0_valid = (k < 8); bus.p0_we = 1'b0; bus.p0_addr = 7'h01;
            bus.p1_valid = (k < 8); bus.p1_we = 1'b0; bus.p1_addr = 7'h02;
            #1;
            if (k < 8) begin
                checks++;
                if ({bus.p0_ready, bus.p1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL alt_grant k=%0d got %b required %b", k, {bus.p0_ready, bus.p1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            @(posedge clk0); @(negedge clk0);
            if (k < 8) begin
                checks++; if (bus.sram_csb0 !== 1'b0) begin errors++; $display("FAIL alt_csb0 k=%0d got %b required 0", k, bus.sram_csb0); end
            end
            if (k >= 2) begin
                exp_p = ((k - 2) % 2 == 1);
                exp_d = exp_p ? 32'h22222222 : 32'h11111111;
                checks++;
                if ({bus.p0_rvalid, bus.p1_rvalid} !== (exp_p ? 2'b01 : 2'b10) || (exp_p ? bus.p1_rdata : bus.p0_rdata) !== exp_d) begin
                    errors++; $display("FAIL alt_return k=%0d got rvalid=%b rdata=%h/%h required %b %h", k, {bus.p0_rvalid, bus.p1_rvalid}, bus.p0_rdata, bus.p1_rdata, exp_p ? 2'b01 : 2'b10, exp_d);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_p1_priority();
        do_reset();
        bus.p1_valid = 1'b1; bus.p1_addr = 7'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b01) begin errors++; $display("FAIL p1only i=%0d got %b required 01", i, {bus.p0_ready, bus.p1_ready}); end
            @(posedge clk0); @(negedge clk0);
        end
        bus.p0_valid = 1'b1; bus.p0_addr = 7'h01;
        #1;
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin errors++; $display("FAIL both_first got %b required 10", {bus.p0_ready, bus.p1_ready}); end
        @(posedge clk0); @(negedge clk0);
        #1;
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b01) begin errors++; $display("FAIL both_second got %b required 01", {bus.p0_ready, bus.p1_ready}); end
        @(posedge clk0); @(negedge clk0);
        bus.p1_valid = 1'b0;
        @(posedge clk0); @(negedge clk0);
        set_idle();
        repeat (3) begin @(posedge clk0); @(negedge clk0); end
        // Last grant went to port 0; the idle gap must not move the pointer.
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        #1;
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b01) begin errors++; $display("FAIL idle_hold got %b required 01", {bus.p0_ready, bus.p1_ready}); end
        @(posedge clk0); @(negedge clk0);
        set_idle();
        repeat (3) begin @(posedge clk0); @(negedge clk0); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_write(1'b0, 7'h00, 32'h12345678);
        bus.p0_valid = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 7'h7F; bus.p0_wdata = 32'hA5A5A5A5;
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.sram_addr0 !== 7'h7F) begin errors++; $display("FAIL wrap_addr got %h required 7f", bus.sram_addr0); end
        bus.p0_we = 1'b0;
        @(posedge clk0); @(negedge clk0);
        bus.p0_addr = 7'h00;
        @(posedge clk0); @(negedge clk0);
        set_idle();
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_7f got rvalid=%b rdata=%h required 1 a5a5a5a5", bus.p0_rvalid, bus.p0_rdata); end
        @(posedge clk0); @(negedge clk0);
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h12345678) begin errors++; $display("FAIL wrap_00 got rvalid=%b rdata=%h required 1 12345678", bus.p0_rvalid, bus.p0_rdata); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        do_write(1'b0, 7'h05, 32'hCAFEF00D);
        bus.p0_valid = 1'b1; bus.p0_addr = 7'h05;
        @(posedge clk0); @(negedge clk0);
        set_idle();
        repeat (2) begin @(posedge clk0); @(negedge clk0); end
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_prior got rvalid=%b rdata=%h required 1 cafef00d", bus.p0_rvalid, bus.p0_rdata); end
        bus.p0_valid = 1'b1; bus.p0_addr = 7'h05;
        @(posedge clk0); @(negedge clk0);
        rst0 = 1'b1;
        #1;
        checks++; if (bus.p0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b required 0", bus.p0_ready); end
        @(posedge clk0); @(negedge clk0);
        checks++; if ({bus.sram_csb0, bus.sram_web0} !== 2'b11 || bus.sram_addr0 !== 7'h00 || bus.sram_din0 !== 32'h0) begin
            errors++; $display("FAIL mid_sram got csb/web=%b addr=%h din=%h required 11 00 0", {bus.sram_csb0, bus.sram_web0}, bus.sram_addr0, bus.sram_din0);
        end
        checks++; if (bus.p0_rdata !== 32'h0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_state got rdata=%h init_done=%b required 0 0", bus.p0_rdata, init_done); end
        set_idle();
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rvalid i=%0d got %b required 00", i, {bus.p0_rvalid, bus.p1_rvalid}); end
            @(posedge clk0); @(negedge clk0);
        end
    endtask

`ifdef SRAM_ARB_INIT_EN
    task automatic test_init();
        int n;
        set_idle();
        rst0 = 1'b1;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        bus.p0_valid = 1'b1; bus.p0_addr = 7'h33;
        n = 0;
        while (!init_done && n < 300) begin
            #1;
            checks++; if (bus.p0_ready !== 1'b0) begin errors++; $display("FAIL init_ready n=%0d got %b required 0", n, bus.p0_ready); end
            @(posedge clk0); @(negedge clk0);
            n++;
        end
        checks++; if (n !== 128) begin errors++; $display("FAIL init_len got %0d required 128", n); end
        @(posedge clk0); @(negedge clk0);
        set_idle();
        repeat (2) begin @(posedge clk0); @(negedge clk0); end
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h0) begin errors++; $display("FAIL init_read got rvalid=%b rdata=%h required 1 0", bus.p0_rvalid, bus.p0_rdata); end
    endtask
`endif

    initial begin
        set_idle();
        test_reset();
        test_write_read();
        test_alternate();
        test_p1_priority();
        test_wrap();
        test_reset_midop();
`ifdef SRAM_ARB_INIT_EN
        test_init();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
